// File: rtl/trigger_run_controller.sv
// Run-control sequencer for one data_trigger channel: shadow/applied config, SET_CONFIG delivery,
// pipeline settle, gating and drain. Macro TRIGGER_RUN_CTRL_HOT_RECONFIG_EN enables in-run reconfig at frame gaps.
module trigger_run_controller #(
    parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
    parameter int MAX_POST_ACQUISITION_LENGTH = 2,
    parameter int DRAIN_TIMEOUT               = 1024,
    parameter int SAMPLE_WIDTH                = 16,
    parameter int ADC_RESOLUTION_WIDTH        = 12,
    localparam int PRE_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1,
    localparam int POST_W = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1,
    localparam int HB_W   = ADC_RESOLUTION_WIDTH + 1
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            RUN_START,
    input  logic                            RUN_STOP,
    input  logic                            CFG_WE,
    input  logic        [1:0]               CFG_ACQUIRE_MODE,
    input  logic signed [SAMPLE_WIDTH-1:0]  CFG_RISING_EDGE_THRESHOLD,
    input  logic signed [SAMPLE_WIDTH-1:0]  CFG_FALLING_EDGE_THRESHOLD,
    input  logic signed [HB_W-1:0]          CFG_H_GAIN_BASELINE,
    input  logic signed [SAMPLE_WIDTH-1:0]  CFG_L_GAIN_BASELINE,
    input  logic signed [SAMPLE_WIDTH-1:0]  CFG_MODE_SWITCH_UPPER_THRESHOLD,
    input  logic signed [SAMPLE_WIDTH-1:0]  CFG_MODE_SWITCH_LOWER_THRESHOLD,
    input  logic        [PRE_W-1:0]         CFG_PRE_ACQUISITION_LENGTH,
    input  logic        [POST_W-1:0]        CFG_POST_ACQUISITION_LENGTH,
    input  logic                            FRAME_BUSY,
    output logic                            SET_CONFIG,
    output logic                            STOP,
    output logic        [1:0]               ACQUIRE_MODE,
    output logic signed [SAMPLE_WIDTH-1:0]  RISING_EDGE_THRESHOLD,
    output logic signed [SAMPLE_WIDTH-1:0]  FALLING_EDGE_THRESHOLD,
    output logic signed [HB_W-1:0]          H_GAIN_BASELINE,
    output logic signed [SAMPLE_WIDTH-1:0]  L_GAIN_BASELINE,
    output logic signed [SAMPLE_WIDTH-1:0]  MODE_SWITCH_UPPER_THRESHOLD,
    output logic signed [SAMPLE_WIDTH-1:0]  MODE_SWITCH_LOWER_THRESHOLD,
    output logic        [PRE_W-1:0]         PRE_ACQUISITION_LENGTH,
    output logic        [POST_W-1:0]        POST_ACQUISITION_LENGTH,
    output logic                            GATE_ENABLE,
    output logic                            CFG_PENDING,
    output logic                            CFG_ACK,
    output logic                            DRAIN_TIMEOUT_ERR,
    output logic        [2:0]               STATE
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + MAX_PRE_ACQUISITION_LENGTH + 4) + 1;

    localparam logic        [PRE_W-1:0]        RST_PRE      = PRE_W'(1);
    localparam logic        [POST_W-1:0]       RST_POST     = POST_W'(1);
    localparam logic signed [SAMPLE_WIDTH-1:0] RST_EDGE_THR = SAMPLE_WIDTH'(1024);
    localparam logic signed [HB_W-1:0]         RST_H_BASE   = HB_W'(-1024);
    localparam logic signed [SAMPLE_WIDTH-1:0] RST_L_BASE   = SAMPLE_WIDTH'(128);
    localparam logic signed [SAMPLE_WIDTH-1:0] RST_UPPER    = SAMPLE_WIDTH'(2047);
    localparam logic signed [SAMPLE_WIDTH-1:0] RST_LOWER    = SAMPLE_WIDTH'(-2048);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPLY    = 3'd2,
        S_SETTLE   = 3'd3,
        S_RUN      = 3'd4,
        S_WAIT_GAP = 3'd5,
        S_DRAIN    = 3'd6
    } state_t;

    function automatic logic [PRE_W-1:0] sat_pre(input logic [PRE_W-1:0] len);
        return (int'(len) > MAX_PRE_ACQUISITION_LENGTH) ? PRE_W'(MAX_PRE_ACQUISITION_LENGTH) : len;
    endfunction

    function automatic logic [POST_W-1:0] sat_post(input logic [POST_W-1:0] len);
        return (int'(len) > MAX_POST_ACQUISITION_LENGTH) ? POST_W'(MAX_POST_ACQUISITION_LENGTH) : len;
    endfunction

    state_t                         r_state;
    state_t                         w_next;
    logic                           w_timeout;
    logic                           w_active;
    logic                           w_stop_d;
    logic                           w_gate_d;
    logic                           w_set_d;
    logic        [CNT_W-1:0]        r_cnt;
    logic                           r_stop;
    logic                           r_gate;
    logic                           r_set;
    logic                           r_pending;
    logic                           r_err;

    logic        [1:0]              r_sh_mode,  r_mode;
    logic signed [SAMPLE_WIDTH-1:0] r_sh_rise,  r_rise;
    logic signed [SAMPLE_WIDTH-1:0] r_sh_fall,  r_fall;
    logic signed [HB_W-1:0]         r_sh_hbase, r_hbase;
    logic signed [SAMPLE_WIDTH-1:0] r_sh_lbase, r_lbase;
    logic signed [SAMPLE_WIDTH-1:0] r_sh_upper, r_upper;
    logic signed [SAMPLE_WIDTH-1:0] r_sh_lower, r_lower;
    logic        [PRE_W-1:0]        r_sh_pre,   r_pre;
    logic        [POST_W-1:0]       r_sh_post,  r_post;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:     if (RUN_START && !RUN_STOP) w_next = S_APPLY;
            S_APPLY:    w_next = RUN_STOP ? S_IDLE : S_SETTLE;
            S_SETTLE: begin
                if (RUN_STOP)                 w_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))  w_next = S_RUN;
            end
            S_RUN: begin
                if (RUN_STOP) w_next = S_DRAIN;
`ifdef TRIGGER_RUN_CTRL_HOT_RECONFIG_EN
                else if (r_pending) w_next = FRAME_BUSY ? S_WAIT_GAP : S_APPLY;
`endif
            end
            S_WAIT_GAP: begin
                if (RUN_STOP)         w_next = S_DRAIN;
                else if (!FRAME_BUSY) w_next = S_APPLY;
            end
            S_DRAIN: begin
                if (!FRAME_BUSY) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with STATE.
    always_comb begin
        w_active = (w_next == S_RUN) || (w_next == S_WAIT_GAP) || (w_next == S_DRAIN);
        w_stop_d = !w_active;
        w_gate_d = w_active;
        w_set_d  = (w_next == S_APPLY);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_stop    <= 1'b1;
            r_gate    <= 1'b0;
            r_set     <= 1'b0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_stop <= w_stop_d;
            r_gate <= w_gate_d;
            r_set  <= w_set_d;
            if (CFG_WE)       r_pending <= 1'b1;
            else if (w_set_d) r_pending <= 1'b0;
            if (w_timeout)    r_err     <= 1'b1;
        end
    end

    // One counter serves both SETTLE (down from pre+3) and DRAIN (busy cycles up from 0).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_APPLY:  r_cnt <= CNT_W'(r_pre) + CNT_W'(3);
                S_SETTLE: r_cnt <= r_cnt - CNT_W'(1);
                S_DRAIN:  r_cnt <= r_cnt + CNT_W'(1);
                default:  r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sh_mode  <= '0;
            r_sh_rise  <= RST_EDGE_THR;
            r_sh_fall  <= RST_EDGE_THR;
            r_sh_hbase <= RST_H_BASE;
            r_sh_lbase <= RST_L_BASE;
            r_sh_upper <= RST_UPPER;
            r_sh_lower <= RST_LOWER;
            r_sh_pre   <= RST_PRE;
            r_sh_post  <= RST_POST;
        end else if (CFG_WE) begin
            r_sh_mode  <= CFG_ACQUIRE_MODE;
            r_sh_rise  <= CFG_RISING_EDGE_THRESHOLD;
            r_sh_fall  <= CFG_FALLING_EDGE_THRESHOLD;
            r_sh_hbase <= CFG_H_GAIN_BASELINE;
            r_sh_lbase <= CFG_L_GAIN_BASELINE;
            r_sh_upper <= CFG_MODE_SWITCH_UPPER_THRESHOLD;
            r_sh_lower <= CFG_MODE_SWITCH_LOWER_THRESHOLD;
            r_sh_pre   <= CFG_PRE_ACQUISITION_LENGTH;
            r_sh_post  <= CFG_POST_ACQUISITION_LENGTH;
        end
    end

    // Applied set loads on the edge into APPLY; a same-edge write lands only in the shadow.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_mode  <= '0;
            r_rise  <= RST_EDGE_THR;
            r_fall  <= RST_EDGE_THR;
            r_hbase <= RST_H_BASE;
            r_lbase <= RST_L_BASE;
            r_upper <= RST_UPPER;
            r_lower <= RST_LOWER;
            r_pre   <= RST_PRE;
            r_post  <= RST_POST;
        end else if (w_set_d) begin
            r_mode  <= r_sh_mode;
            r_rise  <= r_sh_rise;
            r_fall  <= r_sh_fall;
            r_hbase <= r_sh_hbase;
            r_lbase <= r_sh_lbase;
            r_upper <= r_sh_upper;
            r_lower <= r_sh_lower;
            r_pre   <= sat_pre(r_sh_pre);
            r_post  <= sat_post(r_sh_post);
        end
    end

    assign STATE                       = r_state;
    assign STOP                        = r_stop;
    assign GATE_ENABLE                 = r_gate;
    assign SET_CONFIG                  = r_set;
    assign CFG_ACK                     = r_set;
    assign CFG_PENDING                 = r_pending;
    assign DRAIN_TIMEOUT_ERR           = r_err;
    assign ACQUIRE_MODE                = r_mode;
    assign RISING_EDGE_THRESHOLD       = r_rise;
    assign FALLING_EDGE_THRESHOLD      = r_fall;
    assign H_GAIN_BASELINE             = r_hbase;
    assign L_GAIN_BASELINE             = r_lbase;
    assign MODE_SWITCH_UPPER_THRESHOLD = r_upper;
    assign MODE_SWITCH_LOWER_THRESHOLD = r_lower;
    assign PRE_ACQUISITION_LENGTH      = r_pre;
    assign POST_ACQUISITION_LENGTH     = r_post;

endmodule

// File: tb/tb_trigger_run_controller.sv
// Testbench for trigger_run_controller: directed scenarios plus randomized traffic against a
// transaction-level reference model (absolute edge numbers, busy-cycle tally, saturated copies).
module tb_trigger_run_controller;

    localparam int MAXP = 2;
    localparam int MAXQ = 2;
    localparam int TO   = 8;
    localparam int SW   = 16;
    localparam int AW   = 12;
    localparam int PW   = 2;
    localparam int QW   = 2;
    localparam int HW   = AW + 1;
`ifdef TRIGGER_RUN_CTRL_HOT_RECONFIG_EN
    localparam bit HOT = 1'b1;
`else
    localparam bit HOT = 1'b0;
`endif

    typedef struct {
        int mode; int pre; int post; int rise; int fall; int hb; int lb; int up; int lo;
    } cfg_t;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic RUN_START = 1'b0, RUN_STOP = 1'b0, CFG_WE = 1'b0, FRAME_BUSY = 1'b0;
    cfg_t i_cfg;

    logic        [1:0]    CFG_ACQUIRE_MODE;
    logic signed [SW-1:0] CFG_RISING_EDGE_THRESHOLD, CFG_FALLING_EDGE_THRESHOLD, CFG_L_GAIN_BASELINE;
    logic signed [SW-1:0] CFG_MODE_SWITCH_UPPER_THRESHOLD, CFG_MODE_SWITCH_LOWER_THRESHOLD;
    logic signed [HW-1:0] CFG_H_GAIN_BASELINE;
    logic        [PW-1:0] CFG_PRE_ACQUISITION_LENGTH;
    logic        [QW-1:0] CFG_POST_ACQUISITION_LENGTH;

    logic                 SET_CONFIG, STOP, GATE_ENABLE, CFG_PENDING, CFG_ACK, DRAIN_TIMEOUT_ERR;
    logic        [2:0]    STATE;
    logic        [1:0]    ACQUIRE_MODE;
    logic signed [SW-1:0] RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD, L_GAIN_BASELINE;
    logic signed [SW-1:0] MODE_SWITCH_UPPER_THRESHOLD, MODE_SWITCH_LOWER_THRESHOLD;
    logic signed [HW-1:0] H_GAIN_BASELINE;
    logic        [PW-1:0] PRE_ACQUISITION_LENGTH;
    logic        [QW-1:0] POST_ACQUISITION_LENGTH;

    assign CFG_ACQUIRE_MODE                = 2'(i_cfg.mode);
    assign CFG_RISING_EDGE_THRESHOLD       = SW'(i_cfg.rise);
    assign CFG_FALLING_EDGE_THRESHOLD      = SW'(i_cfg.fall);
    assign CFG_H_GAIN_BASELINE             = HW'(i_cfg.hb);
    assign CFG_L_GAIN_BASELINE             = SW'(i_cfg.lb);
    assign CFG_MODE_SWITCH_UPPER_THRESHOLD = SW'(i_cfg.up);
    assign CFG_MODE_SWITCH_LOWER_THRESHOLD = SW'(i_cfg.lo);
    assign CFG_PRE_ACQUISITION_LENGTH      = PW'(i_cfg.pre);
    assign CFG_POST_ACQUISITION_LENGTH     = QW'(i_cfg.post);

    trigger_run_controller #(
        .MAX_PRE_ACQUISITION_LENGTH (MAXP),
        .MAX_POST_ACQUISITION_LENGTH(MAXQ),
        .DRAIN_TIMEOUT              (TO),
        .SAMPLE_WIDTH               (SW),
        .ADC_RESOLUTION_WIDTH       (AW)
    ) dut (
        .ACLK                           (ACLK),
        .ARESETN                        (ARESETN),
        .RUN_START                      (RUN_START),
        .RUN_STOP                       (RUN_STOP),
        .CFG_WE                         (CFG_WE),
        .CFG_ACQUIRE_MODE               (CFG_ACQUIRE_MODE),
        .CFG_RISING_EDGE_THRESHOLD      (CFG_RISING_EDGE_THRESHOLD),
        .CFG_FALLING_EDGE_THRESHOLD     (CFG_FALLING_EDGE_THRESHOLD),
        .CFG_H_GAIN_BASELINE            (CFG_H_GAIN_BASELINE),
        .CFG_L_GAIN_BASELINE            (CFG_L_GAIN_BASELINE),
        .CFG_MODE_SWITCH_UPPER_THRESHOLD(CFG_MODE_SWITCH_UPPER_THRESHOLD),
        .CFG_MODE_SWITCH_LOWER_THRESHOLD(CFG_MODE_SWITCH_LOWER_THRESHOLD),
        .CFG_PRE_ACQUISITION_LENGTH     (CFG_PRE_ACQUISITION_LENGTH),
        .CFG_POST_ACQUISITION_LENGTH    (CFG_POST_ACQUISITION_LENGTH),
        .FRAME_BUSY                     (FRAME_BUSY),
        .SET_CONFIG                     (SET_CONFIG),
        .STOP                           (STOP),
        .ACQUIRE_MODE                   (ACQUIRE_MODE),
        .RISING_EDGE_THRESHOLD          (RISING_EDGE_THRESHOLD),
        .FALLING_EDGE_THRESHOLD         (FALLING_EDGE_THRESHOLD),
        .H_GAIN_BASELINE                (H_GAIN_BASELINE),
        .L_GAIN_BASELINE                (L_GAIN_BASELINE),
        .MODE_SWITCH_UPPER_THRESHOLD    (MODE_SWITCH_UPPER_THRESHOLD),
        .MODE_SWITCH_LOWER_THRESHOLD    (MODE_SWITCH_LOWER_THRESHOLD),
        .PRE_ACQUISITION_LENGTH         (PRE_ACQUISITION_LENGTH),
        .POST_ACQUISITION_LENGTH        (POST_ACQUISITION_LENGTH),
        .GATE_ENABLE                    (GATE_ENABLE),
        .CFG_PENDING                    (CFG_PENDING),
        .CFG_ACK                        (CFG_ACK),
        .DRAIN_TIMEOUT_ERR              (DRAIN_TIMEOUT_ERR),
        .STATE                          (STATE)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phases named by the spec's state numbers, timed by absolute edge counts.
    int   m_state, m_edge, m_run_edge, m_dbusy;
    bit   m_pend, m_err;
    cfg_t m_sh, m_app;

    function automatic cfg_t def_cfg();
        cfg_t c;
        c.mode = 0; c.pre = 1; c.post = 1; c.rise = 1024; c.fall = 1024;
        c.hb = -1024; c.lb = 128; c.up = 2047; c.lo = -2048;
        return c;
    endfunction

    function automatic cfg_t saturate(input cfg_t c);
        cfg_t s = c;
        if (s.pre  > MAXP) s.pre  = MAXP;
        if (s.post > MAXQ) s.post = MAXQ;
        return s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_edge = 0; m_run_edge = 0; m_dbusy = 0;
        m_pend = 1'b0; m_err = 1'b0;
        m_sh = def_cfg(); m_app = def_cfg();
    endtask

    task automatic model_edge();
        int nxt = m_state;
        m_edge++;
        case (m_state)
            0: if (RUN_START && !RUN_STOP) nxt = 2;
            2: if (RUN_STOP) nxt = 0;
               else begin nxt = 3; m_run_edge = m_edge + m_app.pre + 3; end
            3: if (RUN_STOP) nxt = 0; else if (m_edge == m_run_edge) nxt = 4;
            4: if (RUN_STOP) begin nxt = 6; m_dbusy = 0; end
               else if (HOT && m_pend) nxt = FRAME_BUSY ? 5 : 2;
            5: if (RUN_STOP) begin nxt = 6; m_dbusy = 0; end
               else if (!FRAME_BUSY) nxt = 2;
            6: if (!FRAME_BUSY) nxt = 0;
               else begin
                   m_dbusy++;
                   if (m_dbusy == TO) begin nxt = 0; m_err = 1'b1; end
               end
            default: nxt = 0;
        endcase
        if (nxt == 2) m_app = saturate(m_sh);
        if (CFG_WE) begin m_sh = i_cfg; m_pend = 1'b1; end
        else if (nxt == 2) m_pend = 1'b0;
        m_state = nxt;
    endtask

    task automatic check_all();
        bit act = (m_state == 4) || (m_state == 5) || (m_state == 6);
        chk("state", STATE, m_state);
        chk("stop", STOP, !act);
        chk("gate", GATE_ENABLE, act);
        chk("set_config", SET_CONFIG, m_state == 2);
        chk("cfg_ack", CFG_ACK, m_state == 2);
        chk("pending", CFG_PENDING, m_pend);
        chk("timeout_err", DRAIN_TIMEOUT_ERR, m_err);
        chk("mode", ACQUIRE_MODE, m_app.mode);
        chk("pre", PRE_ACQUISITION_LENGTH, m_app.pre);
        chk("post", POST_ACQUISITION_LENGTH, m_app.post);
        chk("rising", RISING_EDGE_THRESHOLD, m_app.rise);
        chk("falling", FALLING_EDGE_THRESHOLD, m_app.fall);
        chk("h_base", H_GAIN_BASELINE, m_app.hb);
        chk("l_base", L_GAIN_BASELINE, m_app.lb);
        chk("upper", MODE_SWITCH_UPPER_THRESHOLD, m_app.up);
        chk("lower", MODE_SWITCH_LOWER_THRESHOLD, m_app.lo);
    endtask

    task automatic step();
        @(posedge ACLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk("rst_state", STATE, 0);
        chk("rst_stop", STOP, 1);
        chk("rst_gate", GATE_ENABLE, 0);
        chk("rst_set", SET_CONFIG, 0);
        chk("rst_ack", CFG_ACK, 0);
        chk("rst_pending", CFG_PENDING, 0);
        chk("rst_err", DRAIN_TIMEOUT_ERR, 0);
        chk("rst_pre", PRE_ACQUISITION_LENGTH, 1);
        chk("rst_post", POST_ACQUISITION_LENGTH, 1);
        chk("rst_rising", RISING_EDGE_THRESHOLD, 1024);
        chk("rst_h_base", H_GAIN_BASELINE, -1024);
        chk("rst_l_base", L_GAIN_BASELINE, 128);
        chk("rst_upper", MODE_SWITCH_UPPER_THRESHOLD, 2047);
        chk("rst_lower", MODE_SWITCH_LOWER_THRESHOLD, -2048);
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic wait_state(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(STATE) == target) break;
            step();
        end
        chk(tag, STATE, target);
    endtask

    task automatic measure_start(input string tag, input int gate_cycle);
        int gate_c = -1;
        int sets = 1;
        for (int c = 2; c < 16; c++) begin
            step();
            if (SET_CONFIG) sets++;
            if (GATE_ENABLE && gate_c < 0) gate_c = c;
        end
        chk({tag, "_gate_cycle"}, gate_c, gate_cycle);
        chk({tag, "_set_count"}, sets, 1);
    endtask

    task automatic rand_cfg();
        i_cfg.mode = int'($urandom_range(0, 3));
        i_cfg.pre  = int'($urandom_range(0, 3));
        i_cfg.post = int'($urandom_range(0, 3));
        i_cfg.rise = int'($urandom_range(0, 65535)) - 32768;
        i_cfg.fall = int'($urandom_range(0, 65535)) - 32768;
        i_cfg.hb   = int'($urandom_range(0, 8191)) - 4096;
        i_cfg.lb   = int'($urandom_range(0, 65535)) - 32768;
        i_cfg.up   = int'($urandom_range(0, 65535)) - 32768;
        i_cfg.lo   = int'($urandom_range(0, 65535)) - 32768;
    endtask

    initial begin
        int sets;
        i_cfg = def_cfg();
        model_reset();
        do_reset();

        // Start with defaults: SET_CONFIG in cycle 1, gate in cycle 6.
        repeat (2) step();
        RUN_START = 1'b1;
        step();
        RUN_START = 1'b0;
        chk("t1_set_c1", SET_CONFIG, 1);
        chk("t1_rising_c1", RISING_EDGE_THRESHOLD, 1024);
        measure_start("t1", 6);

        // Stop, then stage rising=500 / pre=2 and start again: gate in cycle 7.
        RUN_STOP = 1'b1;
        step();
        RUN_STOP = 1'b0;
        step();
        chk("t2_idle", STATE, 0);
        i_cfg.rise = 500; i_cfg.pre = 2; CFG_WE = 1'b1;
        step();
        CFG_WE = 1'b0;
        RUN_START = 1'b1;
        step();
        RUN_START = 1'b0;
        chk("t2_rising", RISING_EDGE_THRESHOLD, 500);
        chk("t2_pre", PRE_ACQUISITION_LENGTH, 2);
        chk("t2_set", SET_CONFIG, 1);
        measure_start("t2", 7);

        // Oversized pre staged while a frame is in flight.
        FRAME_BUSY = 1'b1;
        step();
        i_cfg.pre = 3; i_cfg.rise = 600; CFG_WE = 1'b1;
        step();
        CFG_WE = 1'b0;
        sets = 0;
        for (int i = 0; i < 10; i++) begin step(); if (SET_CONFIG) sets++; end
        chk("t3_state", STATE, HOT ? 5 : 4);
        chk("t3_no_set", sets, 0);
        FRAME_BUSY = 1'b0;
        step();
        chk("t3_set", SET_CONFIG, HOT ? 1 : 0);
        chk("t3_rising", RISING_EDGE_THRESHOLD, HOT ? 600 : 500);
        chk("t3_pre_sat", PRE_ACQUISITION_LENGTH, 2);
        wait_state("t3_back_run", 4, 20);

        // Start and stop together in RUN: stop wins.
        FRAME_BUSY = 1'b1; RUN_START = 1'b1; RUN_STOP = 1'b1;
        step();
        RUN_START = 1'b0; RUN_STOP = 1'b0;
        chk("t4_drain", STATE, 6);
        chk("t4_drain_gate", GATE_ENABLE, 1);
        repeat (2) step();
        FRAME_BUSY = 1'b0;
        step();
        chk("t4_idle", STATE, 0);
        chk("t4_stop", STOP, 1);

        // Drain with busy stuck high.
        RUN_START = 1'b1;
        step();
        RUN_START = 1'b0;
        wait_state("t5_run", 4, 20);
        FRAME_BUSY = 1'b1; RUN_STOP = 1'b1;
        step();
        RUN_STOP = 1'b0;
        repeat (TO - 1) step();
        chk("t5_still_drain", STATE, 6);
        chk("t5_no_err_yet", DRAIN_TIMEOUT_ERR, 0);
        step();
        chk("t5_idle", STATE, 0);
        chk("t5_err", DRAIN_TIMEOUT_ERR, 1);
        FRAME_BUSY = 1'b0;
        repeat (5) step();
        chk("t5_err_sticky", DRAIN_TIMEOUT_ERR, 1);
        do_reset();

        // Write on the same edge that loads the applied set.
        i_cfg = def_cfg();
        i_cfg.rise = 777; CFG_WE = 1'b1; RUN_START = 1'b1;
        step();
        CFG_WE = 1'b0; RUN_START = 1'b0;
        chk("t6_rising_old", RISING_EDGE_THRESHOLD, 1024);
        chk("t6_pending", CFG_PENDING, 1);
        wait_state("t6_run", 4, 20);
        repeat (12) step();
        chk("t6_rising_later", RISING_EDGE_THRESHOLD, HOT ? 777 : 1024);
        chk("t6_pending_later", CFG_PENDING, HOT ? 0 : 1);
        RUN_STOP = 1'b1;
        step();
        RUN_STOP = 1'b0;
        step();
        RUN_START = 1'b1;
        step();
        RUN_START = 1'b0;
        chk("t6_rising_next_run", RISING_EDGE_THRESHOLD, 777);

        // Randomized traffic, with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            RUN_START = ($urandom_range(0, 19) == 0);
            RUN_STOP  = ($urandom_range(0, 39) == 0);
            CFG_WE    = ($urandom_range(0, 11) == 0);
            if (CFG_WE) rand_cfg();
            if ($urandom_range(0, 5) == 0) FRAME_BUSY = ~FRAME_BUSY;
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
